// File: rtl/sine_offset_seq_pkg.sv
// Shared constants, FSM state type and address helper for the sine offset sequencer.
package sine_offset_seq_pkg;

   localparam logic [2:0] WAVE_OFF   = 3'd7;
   localparam int         WAVE_COUNT = 7;
   localparam int         PHASE_W    = 8;
   localparam int         ADDR_USED  = 3 + PHASE_W;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2
   } seq_state_t;

   function automatic logic [ADDR_USED-1:0] wave_addr(input logic [2:0]         amp,
                                                      input logic [PHASE_W-1:0] phase);
      return {amp, phase};
   endfunction

endpackage

// File: rtl/sine_offset_seq_if.sv
// ROM port bundle between the sequencer (master) and the SINE_WAVES ROM (slave).
interface sine_offset_seq_if #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 9
);
   logic [ADDR_WIDTH-1:0] rom_addr;
   logic [DATA_WIDTH-1:0] rom_dout;

   modport master (output rom_addr, input  rom_dout);
   modport slave  (input  rom_addr, output rom_dout);
endinterface

// File: rtl/sine_offset_seq_phase_acc.sv
// Line/frame phase accumulators. Macro SINE_FRAME_ANIM_EN adds per-frame phase animation.
module sine_phase_acc
   import sine_offset_seq_pkg::*;
(
   input  logic               clk_dot4x,
   input  logic               rst,
   input  logic               frame_start,
   input  logic               step,
   input  logic [PHASE_W-1:0] freq,
   input  logic [PHASE_W-1:0] phase_init,
   input  logic [PHASE_W-1:0] speed,
   output logic [PHASE_W-1:0] phase
);

   logic [PHASE_W-1:0] line_phase;
   logic [PHASE_W-1:0] frame_next;

`ifdef SINE_FRAME_ANIM_EN
   logic [PHASE_W-1:0] frame_phase;
   logic               first_q;

   // First frame after reset seeds from phase_init; later frames accumulate speed.
   always_comb begin
      frame_next = first_q ? phase_init : frame_phase + speed;
   end

   always_ff @(posedge clk_dot4x) begin
      if (rst) begin
         frame_phase <= '0;
         first_q     <= 1'b1;
      end else if (frame_start) begin
         frame_phase <= frame_next;
         first_q     <= 1'b0;
      end
   end
`else
   logic [PHASE_W-1:0] speed_unused;

   assign speed_unused = speed;

   always_comb begin
      frame_next = phase_init;
   end
`endif

   // A frame load in the same cycle as a line step is visible to that line.
   always_comb begin
      phase = frame_start ? frame_next : line_phase;
   end

   always_ff @(posedge clk_dot4x) begin
      if (rst) begin
         line_phase <= '0;
      end else if (step) begin
         line_phase <= phase + freq;
      end else if (frame_start) begin
         line_phase <= frame_next;
      end
   end

endmodule

// File: rtl/sine_offset_seq.sv
// Sequencer feeding SINE_WAVES ROM: forms {wave, phase} addresses per raster line and
// converts the centred sample to a signed offset. Optional macro: SINE_FRAME_ANIM_EN.
module sine_offset_seq
   import sine_offset_seq_pkg::*;
#(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 9
) (
   input  logic                  clk_dot4x,
   input  logic                  rst,
   input  logic                  enable,
   input  logic [2:0]            amp_sel,
   input  logic [PHASE_W-1:0]    freq,
   input  logic [PHASE_W-1:0]    phase_init,
   input  logic [PHASE_W-1:0]    speed,
   input  logic                  frame_start,
   input  logic                  line_start,
   sine_offset_seq_if.master     rom,
   output logic [DATA_WIDTH-1:0] offset,
   output logic                  offset_valid,
   output logic                  busy,
   output logic                  overrun
);

   seq_state_t            state, state_n;
   logic                  start;
   logic                  capture;
   logic                  pending;
   logic [2:0]            amp_q;
   logic [PHASE_W-1:0]    phase;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [ADDR_WIDTH-1:0] addr_c;
   logic [DATA_WIDTH-1:0] sample_c;
   logic                  pend_c;
   logic                  ovr_c;

   sine_phase_acc u_acc (
      .clk_dot4x   (clk_dot4x),
      .rst         (rst),
      .frame_start (frame_start),
      .step        (start),
      .freq        (freq),
      .phase_init  (phase_init),
      .speed       (speed),
      .phase       (phase)
   );

   always_ff @(posedge clk_dot4x) begin
      if (rst) state <= S_IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      start   = 1'b0;
      capture = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (enable && (line_start || pending)) begin
               start   = 1'b1;
               state_n = S_ISSUE;
            end
         end
         S_ISSUE: state_n = S_WAIT;
         S_WAIT: begin
            capture = 1'b1;
            state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_comb begin
      addr_c                = '0;
      addr_c[ADDR_USED-1:0] = wave_addr(amp_sel, phase);
      // Flipping the MSB of the unsigned sample is the same as subtracting mid-scale.
      sample_c = {~rom.rom_dout[DATA_WIDTH-1], rom.rom_dout[DATA_WIDTH-2:0]};
   end

   // Pending/overrun: frame_start clears first, then this cycle's line_start is applied.
   always_comb begin
      pend_c = frame_start ? 1'b0 : pending;
      ovr_c  = frame_start ? 1'b0 : overrun;
      if (!enable) begin
         pend_c = 1'b0;
      end else if (start) begin
         pend_c = pending && line_start && !frame_start;
      end else if (line_start && state != S_IDLE) begin
         if (pend_c) ovr_c  = 1'b1;
         else        pend_c = 1'b1;
      end
   end

   always_ff @(posedge clk_dot4x) begin
      if (rst) begin
         addr_q       <= '0;
         amp_q        <= '0;
         offset       <= '0;
         offset_valid <= 1'b0;
         pending      <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         offset_valid <= capture;
         pending      <= pend_c;
         overrun      <= ovr_c;
         if (start) begin
            addr_q <= addr_c;
            amp_q  <= amp_sel;
         end
         if (!enable) begin
            offset <= '0;
         end else if (capture) begin
            offset <= (amp_q == WAVE_OFF) ? '0 : sample_c;
         end
      end
   end

   assign rom.rom_addr = addr_q;
   assign busy         = (state != S_IDLE);

endmodule

// File: tb/tb_sine_offset_seq.sv
// Self-checking bench for sine_offset_seq with a registered ROM model and phase reference.
module tb_sine_offset_seq;

   localparam int AW = 12;
   localparam int DW = 9;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          enable = 1'b0;
   logic [2:0]    amp_sel = '0;
   logic [7:0]    freq = '0;
   logic [7:0]    phase_init = '0;
   logic [7:0]    speed = '0;
   logic          frame_start = 1'b0;
   logic          line_start = 1'b0;
   logic [DW-1:0] offset;
   logic          offset_valid;
   logic          busy;
   logic          overrun;

   logic [DW-1:0] rom_mem [0:(1<<AW)-1];

   int unsigned errors = 0;
   int unsigned checks = 0;

   logic [7:0] m_lp;
   logic [7:0] m_fp;
   bit         m_first;

   sine_offset_seq_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) rom_if ();

   sine_offset_seq #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk_dot4x    (clk),
      .rst          (rst),
      .enable       (enable),
      .amp_sel      (amp_sel),
      .freq         (freq),
      .phase_init   (phase_init),
      .speed        (speed),
      .frame_start  (frame_start),
      .line_start   (line_start),
      .rom          (rom_if),
      .offset       (offset),
      .offset_valid (offset_valid),
      .busy         (busy),
      .overrun      (overrun)
   );

   always #5 clk = ~clk;

   always @(posedge clk) rom_if.rom_dout <= rom_mem[rom_if.rom_addr];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] exp_offset(input logic [AW-1:0] addr);
      int v;
      if (addr[10:8] == 3'd7) return '0;
      v = (int'(rom_mem[addr]) - 256) & 511;
      return v[DW-1:0];
   endfunction

   task automatic model_reset();
      m_lp = '0;
      m_fp = '0;
      m_first = 1'b1;
   endtask

   task automatic model_frame();
`ifdef SINE_FRAME_ANIM_EN
      m_fp = m_first ? phase_init : m_fp + speed;
`else
      m_fp = phase_init;
`endif
      m_first = 1'b0;
      m_lp = m_fp;
   endtask

   function automatic logic [AW-1:0] model_addr();
      logic [AW-1:0] a;
      a = '0;
      a[10:8] = amp_sel;
      a[7:0]  = m_lp;
      return a;
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_reset();
   endtask

   task automatic pulse_frame();
      frame_start = 1'b1;
      model_frame();
      tick();
      frame_start = 1'b0;
   endtask

   // One complete lookup; optional frame_start in the same cycle as line_start.
   task automatic do_line(input bit with_frame, input string tag);
      logic [AW-1:0] ea;
      if (with_frame) begin
         frame_start = 1'b1;
         model_frame();
      end
      ea = model_addr();
      m_lp = m_lp + freq;
      line_start = 1'b1;
      tick();
      line_start  = 1'b0;
      frame_start = 1'b0;
      chk({tag, ".addr"}, 32'(rom_if.rom_addr), 32'(ea));
      chk({tag, ".busy"}, 32'(busy), 32'd1);
      tick();
      chk({tag, ".novalid"}, 32'(offset_valid), 32'd0);
      tick();
      chk({tag, ".valid"}, 32'(offset_valid), 32'd1);
      chk({tag, ".offset"}, 32'(offset), 32'(exp_offset(ea)));
      tick();
      chk({tag, ".pulse"}, 32'(offset_valid), 32'd0);
   endtask

   initial begin
      logic [AW-1:0] a1, a2;
      logic [7:0]    fexp [3];

      for (int i = 0; i < (1 << AW); i++) rom_mem[i] = DW'($urandom);
      model_reset();

      // Reset state
      tick();
      tick();
      chk("rst.addr",    32'(rom_if.rom_addr), 32'd0);
      chk("rst.offset",  32'(offset), 32'd0);
      chk("rst.valid",   32'(offset_valid), 32'd0);
      chk("rst.busy",    32'(busy), 32'd0);
      chk("rst.overrun", 32'(overrun), 32'd0);
      rst = 1'b0;
      model_reset();

      // Basic lookup and sample conversion extremes
      enable = 1'b1; amp_sel = 3'd0; freq = 8'd4; phase_init = 8'h10; speed = 8'd3;
      rom_mem[12'h010] = 9'h1FF;
      rom_mem[12'h014] = 9'h000;
      rom_mem[12'h018] = 9'h100;
      do_line(1'b1, "t1");
      chk("t1.const_off", 32'(offset), 32'h0FF);
      do_line(1'b0, "t2a");
      chk("t2a.const_off", 32'(offset), 32'h100);
      do_line(1'b0, "t2b");
      amp_sel = 3'd7;
      do_line(1'b0, "t2off");
      chk("t2off.const_off", 32'(offset), 32'd0);

      // Phase wrap from a fresh first frame
      do_reset();
      amp_sel = 3'd1; phase_init = 8'hFE; freq = 8'd4;
      do_line(1'b1, "t3a");
      chk("t3a.phase", 32'(rom_if.rom_addr[7:0]), 32'hFE);
      do_line(1'b0, "t3b");
      chk("t3b.phase", 32'(rom_if.rom_addr[7:0]), 32'h02);
      do_line(1'b0, "t3c");
      chk("t3c.phase", 32'(rom_if.rom_addr[7:0]), 32'h06);

      // Three back-to-back line_starts: one queued, one dropped
      amp_sel = 3'd2;
      a1 = model_addr(); m_lp = m_lp + freq;
      a2 = model_addr(); m_lp = m_lp + freq;
      line_start = 1'b1;
      tick();
      chk("ovr.addr1", 32'(rom_if.rom_addr), 32'(a1));
      tick();
      tick();
      line_start = 1'b0;
      chk("ovr.valid1", 32'(offset_valid), 32'd1);
      chk("ovr.off1", 32'(offset), 32'(exp_offset(a1)));
      chk("ovr.flag", 32'(overrun), 32'd1);
      tick();
      chk("ovr.addr2", 32'(rom_if.rom_addr), 32'(a2));
      tick();
      tick();
      chk("ovr.valid2", 32'(offset_valid), 32'd1);
      chk("ovr.off2", 32'(offset), 32'(exp_offset(a2)));
      tick();
      chk("ovr.idle", 32'(busy), 32'd0);
      chk("ovr.sticky", 32'(overrun), 32'd1);
      pulse_frame();
      chk("ovr.clear", 32'(overrun), 32'd0);

      // frame_start together with line_start
      freq = 8'd9;
      do_line(1'b1, "t5fl");
      do_line(1'b0, "t5next");

      // Reset while the lookup sits in ISSUE
      line_start = 1'b1;
      tick();
      line_start = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_reset();
      chk("rsti.addr",  32'(rom_if.rom_addr), 32'd0);
      chk("rsti.busy",  32'(busy), 32'd0);
      chk("rsti.valid", 32'(offset_valid), 32'd0);
      chk("rsti.off",   32'(offset), 32'd0);
      tick();
      chk("rsti.nopulse1", 32'(offset_valid), 32'd0);
      tick();
      chk("rsti.nopulse2", 32'(offset_valid), 32'd0);

      // Disable during a lookup: completes with a zero offset; line_start then ignored
      amp_sel = 3'd0; phase_init = 8'h40; freq = 8'd1;
      pulse_frame();
      a1 = model_addr(); m_lp = m_lp + freq;
      line_start = 1'b1;
      tick();
      line_start = 1'b0;
      enable = 1'b0;
      chk("en.addr", 32'(rom_if.rom_addr), 32'(a1));
      tick();
      tick();
      chk("en.valid", 32'(offset_valid), 32'd1);
      chk("en.zero", 32'(offset), 32'd0);
      line_start = 1'b1;
      tick();
      line_start = 1'b0;
      chk("en.ignored", 32'(busy), 32'd0);
      tick();
      chk("en.still_idle", 32'(busy), 32'd0);
      enable = 1'b1;
      do_line(1'b0, "en.resume");

      // Frame animation: first line of each frame
      do_reset();
      amp_sel = 3'd3; phase_init = 8'h10; speed = 8'd3; freq = 8'd5;
`ifdef SINE_FRAME_ANIM_EN
      fexp[0] = 8'h10; fexp[1] = 8'h13; fexp[2] = 8'h16;
`else
      fexp[0] = 8'h10; fexp[1] = 8'h10; fexp[2] = 8'h10;
`endif
      for (int f = 0; f < 3; f++) begin
         do_line(1'b1, "anim");
         chk("anim.phase", 32'(rom_if.rom_addr[7:0]), 32'(fexp[f]));
         do_line(1'b0, "anim2");
      end

      // Randomized lines against the reference model
      for (int n = 0; n < 40; n++) begin
         amp_sel = 3'($urandom_range(0, 7));
         freq    = 8'($urandom);
         speed   = 8'($urandom);
         if ($urandom_range(0, 3) == 0) phase_init = 8'($urandom);
         do_line($urandom_range(0, 3) == 0, "rand");
         for (int g = $urandom_range(0, 2); g > 0; g--) tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
